// File: rtl/muldiv_stage.sv
// RV32M multiply/divide execute stage: waits out a combinational multiplier or
// runs a 32-cycle restoring divider, then presents a registered result with a done pulse.
module muldiv_stage #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_value,
  input  logic [31:0] rs2_value,
  input  logic [31:0] mul_out,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DONE} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q, dsr_d;
  logic [31:0] result_q, result_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        is_rem_q, is_rem_d;

  logic        accept;
  logic        signed_op;
  logic        div_zero;
  logic        div_ovf;
  logic        special;
  logic [31:0] special_res;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] quo_step;
  logic [31:0] rem_step;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] fixup(input logic [31:0] quo, input logic [31:0] rem,
                                        input logic nq, input logic nr, input logic sel_rem);
    logic [31:0] q_s;
    logic [31:0] r_s;
    q_s = nq ? (~quo + 32'd1) : quo;
    r_s = nr ? (~rem + 32'd1) : rem;
    return sel_rem ? r_s : q_s;
  endfunction

  assign accept    = start & ~flush;
  assign signed_op = ~funct3[0];
  assign div_zero  = (rs2_value == 32'd0);
  assign div_ovf   = signed_op & (rs1_value == 32'h8000_0000) & (rs2_value == 32'hFFFF_FFFF);
  assign special   = div_zero | div_ovf;

  // Divide-by-zero wins over overflow; both bypass the iterative loop.
  always_comb begin
    special_res = 32'd0;
    if (div_zero) special_res = funct3[1] ? rs1_value : 32'hFFFF_FFFF;
    else          special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // One restoring step: the shifted partial remainder fits 33 bits, so the borrow is diff[32].
  assign shifted  = {rem_q, quo_q[31]};
  assign diff     = shifted - {1'b0, dsr_q};
  assign ge       = ~diff[32];
  assign quo_step = {quo_q[30:0], ge};
  assign rem_step = ge ? diff[31:0] : shifted[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (!funct3[2])   state_d = MUL_WAIT;
            else if (special) state_d = DONE;
            else              state_d = DIV_RUN;
          end
        end
        MUL_WAIT: if (cnt_q == 6'd1) state_d = DONE;
        DIV_RUN:  if (cnt_q == 6'd1) state_d = DONE;
        DONE:     state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = ((state_q == IDLE) & accept & rst) | (state_q == MUL_WAIT) | (state_q == DIV_RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    result_d  = result_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    if (flush) begin
      cnt_d = 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (!funct3[2]) begin
              cnt_d = 6'(MUL_LAT);
            end else if (special) begin
              result_d = special_res;
            end else begin
              cnt_d     = 6'd32;
              quo_d     = mag32(rs1_value, signed_op & rs1_value[31]);
              dsr_d     = mag32(rs2_value, signed_op & rs2_value[31]);
              rem_d     = 32'd0;
              neg_quo_d = signed_op & (rs1_value[31] ^ rs2_value[31]);
              neg_rem_d = signed_op & rs1_value[31];
              is_rem_d  = funct3[1];
            end
          end
        end
        MUL_WAIT: begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) result_d = mul_out;
        end
        DIV_RUN: begin
          cnt_d = cnt_q - 6'd1;
          quo_d = quo_step;
          rem_d = rem_step;
          if (cnt_q == 6'd1) result_d = fixup(quo_step, rem_step, neg_quo_q, neg_rem_q, is_rem_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 6'd0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      dsr_q     <= 32'd0;
      result_q  <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dsr_q     <= dsr_d;
      result_q  <= result_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
    end
  end

  assign result = result_q;

endmodule

// File: doc/muldiv_stage.md
MULDIV_STAGE -- requirements
Module: muldiv_stage

Interface
REQ-001 Parameter MUL_LAT, default 1, legal 1..4: cycles allowed for the combinational multiplier to settle before mul_out is captured.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  M-extension instruction valid in EX (OP opcode, funct7=0000001).
REQ-005 funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_value  input  32  first operand (dividend for div/rem).
REQ-007 rs2_value  input  32  second operand (divisor for div/rem).
REQ-008 mul_out  input  32  result from the combinational MUL unit, driven from the same funct3/operands.
REQ-009 flush  input  1  kill the in-flight operation (branch/trap).
REQ-010 busy  output  1  pipeline stall request; ID/EX operands and funct3 held stable while high.
REQ-011 done  output  1  one-cycle pulse: result valid.
REQ-012 result  output  32  registered M-extension result for EX/MEM.

Function
REQ-013 FSM states SHALL be IDLE, MUL_WAIT, DIV_RUN, DONE; reset and flush targets are IDLE.
REQ-014 IDLE with start=1, flush=0: funct3[2]=0 -> MUL_WAIT, wait counter loaded with MUL_LAT; funct3[2]=1 -> special-case check (REQ-020/021) -> DONE, else DIV_RUN with bit counter loaded with 32.
REQ-015 busy SHALL be combinational: (IDLE & start & ~flush) | MUL_WAIT | DIV_RUN; low in DONE and during reset.
REQ-016 MUL_WAIT: counter decrements each cycle; on the cycle it reads 1, mul_out is registered into result and state -> DONE.
REQ-017 DIV_RUN: restoring division on unsigned magnitudes, one quotient bit per cycle, MSB first, 32 iterations, 33-bit partial-remainder subtract; after the last iteration, sign fix-up is applied, result loaded, state -> DONE.
REQ-018 Signed ops (DIV, REM): magnitudes taken from two's complement; quotient negated if operand signs differ; remainder takes dividend sign. DIVU/REMU: no sign handling.
REQ-019 Result select: DIV/DIVU -> quotient, REM/REMU -> remainder.
REQ-020 Divide by zero (rs2_value=0): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1_value; no DIV_RUN.
REQ-021 Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0x00000000; no DIV_RUN.
REQ-022 DONE: done=1 for exactly one cycle, busy=0, then unconditionally -> IDLE; start during DONE SHALL be ignored.
REQ-023 Latency from start cycle T: MUL ops done at T+MUL_LAT+1; normal div/rem done at T+33; special cases done at T+1.
REQ-024 flush SHALL have priority over start and over all states: next state IDLE, done never pulses for the killed op, result unchanged.
REQ-025 result SHALL hold its last value until the next done; it is only written on entry to DONE.
REQ-026 Operands and funct3 SHALL be latched internally at start; later input changes do not affect a div in flight.

Reset
REQ-027 rst low SHALL asynchronously force state IDLE, counters 0, done 0, result 0x00000000, busy 0, independent of clk.
REQ-028 Reset mid-operation SHALL abort it with no done pulse; first start accepted on the first rising edge with rst high.

Verification
REQ-029 MUL_LAT=1, MULHU 0xFFFFFFFF*0xFFFFFFFF (mul_out=0xFFFFFFFE) -> busy at T, T+1; done at T+2; result 0xFFFFFFFE.
REQ-030 DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> busy T..T+32, done T+33, result 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
REQ-031 DIVU 100/0 -> done T+1, result 0xFFFFFFFF; REMU 100/0 -> result 0x00000064; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-032 DIVU 0xFFFFFFFF/0x10 issued, flush at T+10 -> busy low at T+11, no done pulse, result keeps prior value; new DIVU 7/2 at T+12 -> result 0x00000003 at T+45.
REQ-033 rst low mid-DIV_RUN (T+5) -> immediately done=0, busy=0, result=0; start with flush high in IDLE -> busy 0, no state change.
